fifo_wr_arbiter: RTL and testbench

Write-side controller for the async FIFO memory (`wclk_i` domain). It arbitrates NREQ producers round-robin onto the single memory write port, with packet atomicity. It owns the binary and Gray write pointers and generates the registered full flag from the synchronized read pointer. Its outputs drive the memory's write enable, write address and write data directly, and its Gray pointer is exported to the read-domain synchronizer.

---
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: round-robin, packet-atomic
// arbitration of NREQ producers onto the memory write port, plus the write pointers and the full flag.
module fifo_wr_arbiter #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4
) (
  input  logic                     wclk_i,
  input  logic                     wrst_n_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ-1:0]          req_last_i,
  input  logic [NREQ*DATASIZE-1:0] req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [ADDRSIZE:0]        wq2_rptr_i,
  output logic                     wen_o,
  output logic [ADDRSIZE-1:0]      wr_addr_o,
  output logic [DATASIZE-1:0]      wdata_o,
  output logic [ADDRSIZE:0]        wptr_o,
  output logic                     wfull_o,
  output logic [$clog2(NREQ)-1:0]  grant_id_o,
  output logic                     busy_o
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    lock_id_q, lock_id_d;
  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic              wfull_q, wfull_d;
  logic              wen_en_q, wen_en_d;

  logic [IDW-1:0]    win_id;
  logic              win_found;
  logic [IDW-1:0]    grant_id;
  logic              grant_ok;
  logic [NREQ-1:0]   ready_vec;
  logic              sel_last;
  logic              xfer;
  logic [ADDRSIZE:0] wgnext;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NREQ)) s = s - 32'(NREQ);
    return IDW'(s);
  endfunction

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win_id    = rr_ptr_q;
    win_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[wrap_add(rr_ptr_q, i)]) begin
        win_id    = wrap_add(rr_ptr_q, i);
        win_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (sel_last) begin
            rr_ptr_d = wrap_add(win_id, 1);
          end else begin
            state_d   = S_BURST;
            lock_id_d = win_id;
          end
        end
      end
      S_BURST: begin
        if (xfer && sel_last) begin
          state_d  = S_IDLE;
          rr_ptr_d = wrap_add(lock_id_q, 1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    grant_id  = (state_q == S_BURST) ? lock_id_q : win_id;
    grant_ok  = (state_q == S_BURST) | win_found;
    ready_vec = '0;
    if (grant_ok && !wfull_q) ready_vec[grant_id] = 1'b1;
    sel_last  = req_last_i[grant_id];
  end

  // wen_en_q holds writes off until the first edge after reset release.
  assign xfer        = (|(req_valid_i & ready_vec)) & wen_en_q;
  assign req_ready_o = ready_vec;
  assign wen_o       = xfer;
  assign wdata_o     = req_data_i[grant_id*DATASIZE +: DATASIZE];
  assign grant_id_o  = grant_id;
  assign busy_o      = (state_q == S_BURST);
  assign wr_addr_o   = wbin_q[ADDRSIZE-1:0];
  assign wptr_o      = wptr_q;
  assign wfull_o     = wfull_q;

  always_comb begin
    wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, xfer};
    wgnext   = (wbin_d >> 1) ^ wbin_d;
    wptr_d   = wgnext;
    // Full when the next Gray write pointer equals the read pointer with its two MSBs inverted.
    wfull_d  = (wgnext == {~wq2_rptr_i[ADDRSIZE:ADDRSIZE-1], wq2_rptr_i[ADDRSIZE-2:0]});
    wen_en_d = 1'b1;
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wen_en_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      wen_en_q <= wen_en_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: expected writes are queued when
// stimulus is driven and compared when wen_o is observed.
module tb_fifo_wr_arbiter;

  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;

  logic                     wclk = 1'b0;
  logic                     wrst_n;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_last;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          req_ready;
  logic [ADDRSIZE:0]        rptr;
  logic                     wen;
  logic [ADDRSIZE-1:0]      wr_addr;
  logic [DATASIZE-1:0]      wdata;
  logic [ADDRSIZE:0]        wptr;
  logic                     wfull;
  logic [IDW-1:0]           grant_id;
  logic                     busy;

  fifo_wr_arbiter #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE), .NREQ(NREQ)) dut (
    .wclk_i      (wclk),
    .wrst_n_i    (wrst_n),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .wq2_rptr_i  (rptr),
    .wen_o       (wen),
    .wr_addr_o   (wr_addr),
    .wdata_o     (wdata),
    .wptr_o      (wptr),
    .wfull_o     (wfull),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wcnt = 0;
  int   rcnt = 0;
  int   seq  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dat(input int k);
    return 8'(k * 64 + (seq % 64));
  endfunction

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic set_data();
    for (int k = 0; k < NREQ; k++) req_data[k*DATASIZE +: DATASIZE] = dat(k);
  endtask

  task automatic next_cycle();
    @(posedge wclk);
    #1;
    seq++;
    set_data();
  endtask

  task automatic push(input int k);
    sb_q.push_back(exp_t'{id: 2'(k), addr: 4'(wcnt), data: dat(k)});
    wcnt++;
  endtask

  always @(negedge wclk) begin
    if (wen) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_wen", 32'(wen), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check_val("wdata", 32'(wdata), 32'(mon_e.data));
        check_val("wr_grant", 32'(grant_id), 32'(mon_e.id));
        $display("write: grant=%0d addr=%0d data=0x%02h", grant_id, wr_addr, wdata);
      end
    end
  end

  initial begin
    wrst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; rptr = '0;
    set_data();

    // Reset state
    #2;
    req_valid = 4'b0100;
    #1;
    check_val("rst_ready", 32'(req_ready), 32'b0100);
    check_val("rst_wen", 32'(wen), 32'd0);
    req_valid = '0;
    #1;
    check_val("rst_grant", 32'(grant_id), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_wptr", 32'(wptr), 32'd0);
    check_val("rst_wfull", 32'(wfull), 32'd0);
    check_val("rst_addr", 32'(wr_addr), 32'd0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    next_cycle();

    // 8 single-word packets, all requesters valid
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push(i % 4);
      @(negedge wclk);
      check_val("rr_grant", 32'(grant_id), 32'(i % 4));
      check_val("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
      next_cycle();
    end
    req_valid = '0;
    check_val("wptr_gray8", 32'(wptr), 32'b01100);
    check_val("addr_after8", 32'(wr_addr), 32'd8);

    // Move rr_ptr to 1, then requester 1 sends a 3-word packet
    req_valid = 4'b0001; req_last = 4'b0001;
    push(0);
    next_cycle();
    req_valid = 4'b1111; req_last = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) req_last = 4'b1111;
      push(1);
      @(negedge wclk);
      check_val("pkt_ready", 32'(req_ready), 32'b0010);
      check_val("pkt_busy", 32'(busy), (i == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    push(2);
    @(negedge wclk);
    check_val("after_pkt_grant", 32'(grant_id), 32'd2);
    check_val("after_pkt_busy", 32'(busy), 32'd0);
    next_cycle();
    req_valid = '0;

    // Fill to full with the read pointer at 0
    wrst_n = 1'b0; wcnt = 0;
    next_cycle();
    wrst_n = 1'b1;
    next_cycle();
    req_valid = 4'b0100; req_last = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      push(2);
      @(negedge wclk);
      if (i == 15) check_val("not_full_yet", 32'(wfull), 32'd0);
      next_cycle();
    end
    @(negedge wclk);
    check_val("full_set", 32'(wfull), 32'd1);
    check_val("full_ready", 32'(req_ready), 32'd0);
    check_val("full_wen", 32'(wen), 32'd0);
    next_cycle();
    rptr = gray5(1); rcnt = 1;
    @(negedge wclk);
    check_val("full_hold", 32'(wfull), 32'd1);
    next_cycle();
    push(2);
    @(negedge wclk);
    check_val("full_clear", 32'(wfull), 32'd0);
    check_val("clear_ready", 32'(req_ready), 32'b0100);
    next_cycle();
    check_val("full_again", 32'(wfull), 32'd1);

    // Alternate drain and fill for 40 words, crossing both pointer wraps
    for (int r = 0; r < 5; r++) begin
      req_valid = '0;
      rcnt += 8;
      rptr = gray5(rcnt);
      next_cycle();
      check_val("drain_clear", 32'(wfull), 32'd0);
      req_valid = 4'b0001; req_last = 4'b0001;
      for (int j = 0; j < 8; j++) begin
        check_val("wptr_gray", 32'(wptr), 32'(gray5(wcnt)));
        push(0);
        next_cycle();
      end
      @(negedge wclk);
      check_val("wrap_full", 32'(wfull), 32'd1);
      check_val("wrap_full_ready", 32'(req_ready), 32'd0);
      next_cycle();
    end

    // Lock hold while the grantee's valid drops
    req_valid = '0;
    rptr = gray5(wcnt);
    next_cycle();
    check_val("lock_not_full", 32'(wfull), 32'd0);
    req_valid = 4'b1000; req_last = 4'b0000;
    push(3);
    @(negedge wclk);
    check_val("lock_first_grant", 32'(grant_id), 32'd3);
    next_cycle();
    req_valid = 4'b0001; req_last = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      check_val("lock_ready", 32'(req_ready), 32'b1000);
      check_val("lock_grant", 32'(grant_id), 32'd3);
      check_val("lock_busy", 32'(busy), 32'd1);
      next_cycle();
    end
    req_valid = 4'b1001; req_last = 4'b0000;
    push(3);
    next_cycle();
    req_last = 4'b1000;
    push(3);
    next_cycle();
    req_valid = 4'b0001; req_last = 4'b0001;
    push(0);
    @(negedge wclk);
    check_val("resume_grant", 32'(grant_id), 32'd0);
    check_val("resume_busy", 32'(busy), 32'd0);
    next_cycle();
    req_valid = '0;

    // Asynchronous reset in the middle of a burst
    req_valid = 4'b0010; req_last = 4'b0000;
    push(1);
    next_cycle();
    check_val("burst_busy", 32'(busy), 32'd1);
    #1;
    wrst_n = 1'b0;
    rptr = '0;
    wcnt = 0;
    #1;
    check_val("arst_wen", 32'(wen), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_wptr", 32'(wptr), 32'd0);
    check_val("arst_wfull", 32'(wfull), 32'd0);
    check_val("arst_addr", 32'(wr_addr), 32'd0);
    check_val("arst_ready", 32'(req_ready), 32'b0010);
    req_valid = '0;
    #1;
    check_val("arst_grant", 32'(grant_id), 32'd0);
    @(posedge wclk); #3;
    wrst_n = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111;
    @(negedge wclk);
    check_val("release_wen", 32'(wen), 32'd0);
    next_cycle();
    push(0);
    @(negedge wclk);
    check_val("restart_grant", 32'(grant_id), 32'd0);
    next_cycle();
    push(1);
    next_cycle();
    req_valid = '0;
    next_cycle();
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
